spi_coeff_bank: RTL and testbench

Parametrised SPI slave that loads the modulator's coefficient banks through double-buffered (shadow/active) registers and supports read-back over MISO. It runs entirely in the system clock domain and oversamples the SPI pins. Host writes land in a shadow bank. A commit command copies the whole shadow bank to the active outputs in one cycle, so the modulator never sees a half-updated coefficient set. It sits between the external SPI pins and the modulator datapath.

---
 rtl/spi_coeff_bank.sv | 184 ++++++++++++++++++
 tb/tb_spi_coeff_bank.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_coeff_bank.sv
// spi_coeff_bank: SPI (mode 0) slave that loads a double-buffered coefficient
// bank. Host writes land in a shadow bank; a commit copies the whole shadow
// bank to coef_out in one clock so the modulator never sees a partial set.
// The SPI pins are oversampled in the system clock domain.
//
// Ports:
//   clk, rst_n        system clock, async active-low reset
//   sclk, mosi, ss_n  SPI pins (async to clk, synchronised here)
//   miso, miso_oe     read-back data and its output enable
//   coef_out          active bank, entry (ch,tap) at [(ch*TAPS+tap)*COEF_W +: COEF_W]
//   commit_pulse      one-clock strobe when coef_out is updated
//   err_len, err_addr sticky frame-length / unmapped-address flags
//
// Frame: 32 bits MSB first = {rw(1=write), addr[6:0], data[23:0]}.
module spi_coeff_bank #(
    parameter int NUM_CH = 4,
    parameter int TAPS   = 8,
    parameter int COEF_W = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sclk,
    input  logic                          mosi,
    input  logic                          ss_n,
    output logic                          miso,
    output logic                          miso_oe,
    output logic [NUM_CH*TAPS*COEF_W-1:0] coef_out,
    output logic                          commit_pulse,
    output logic                          err_len,
    output logic                          err_addr
);

    localparam int NE = NUM_CH * TAPS;
    localparam int BW = NE * COEF_W;

    typedef enum logic [2:0] {
        IDLE, HEADER, WDATA, RDATA, DONE, WAIT_SS
    } state_t;

    state_t          state, state_next;
    logic [1:0]      sclk_s, mosi_s, ss_s;
    logic            sclk_d, ss_d;
    logic            sclk_rise, sclk_fall, ss_fall, ss_rise;
    logic [5:0]      cnt;
    logic [29:0]     sr;        // oldest 30 received bits; bit 31 (rw) is tracked by state
    logic [23:0]     tx;
    logic [BW-1:0]   shadow;
    logic            frame_end, abort;
    logic [6:0]      hdr_addr, fr_addr;
    logic [COEF_W-1:0] wdata;
    logic [2:0]      ctrl;
    logic [23:0]     rd_val;
    int              rd_base, wr_base;

    function automatic logic is_mapped(input logic [6:0] a);
        return (a != 7'd0) && (int'(a) <= NE);
    endfunction

    // Two-flop synchronisers plus one edge-detect flop. The ss_n chain resets
    // low so a slave select already low at reset release is not seen as a
    // falling edge; a frame only starts after ss_n has been observed high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_s <= '0;
            mosi_s <= '0;
            ss_s   <= '0;
            sclk_d <= 1'b0;
            ss_d   <= 1'b0;
        end else begin
            sclk_s <= {sclk_s[0], sclk};
            mosi_s <= {mosi_s[0], mosi};
            ss_s   <= {ss_s[0], ss_n};
            sclk_d <= sclk_s[1];
            ss_d   <= ss_s[1];
        end
    end

    assign sclk_rise = sclk_s[1] & ~sclk_d;
    assign sclk_fall = ~sclk_s[1] & sclk_d;
    assign ss_fall   = ~ss_s[1] & ss_d;
    assign ss_rise   = ss_s[1] & ~ss_d;

    // Header sits in sr[7:0] once 8 bits are in; at the 32nd rise the full
    // frame is {sr, mosi}, so its address field is sr[29:23].
    assign hdr_addr = sr[6:0];
    assign fr_addr  = sr[29:23];
    assign wdata    = {sr[COEF_W-2:0], mosi_s[1]};
    assign ctrl     = {sr[1:0], mosi_s[1]};
    assign rd_base  = (int'(hdr_addr) - 1) * COEF_W;
    assign wr_base  = (int'(fr_addr) - 1) * COEF_W;

    always_comb begin
        rd_val = '0;
        if (hdr_addr == 7'd0)
            rd_val[1:0] = {err_len, err_addr};
        else if (is_mapped(hdr_addr))
            rd_val[COEF_W-1:0] = shadow[rd_base +: COEF_W];
    end

    always_comb begin
        state_next = state;
        frame_end  = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE:    if (ss_fall) state_next = HEADER;
            HEADER: begin
                if (ss_rise)           abort = 1'b1;
                else if (cnt == 6'd8)  state_next = sr[7] ? WDATA : RDATA;
            end
            WDATA, RDATA: begin
                if (ss_rise) abort = 1'b1;
                else if (sclk_rise && cnt == 6'd31) begin
                    frame_end  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = WAIT_SS;
            // level test: an ss_n rise landing on the single DONE cycle
            // must not strand the FSM here
            WAIT_SS: if (ss_s[1]) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort) state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            sr           <= '0;
            tx           <= '0;
            shadow       <= '0;
            coef_out     <= '0;
            commit_pulse <= 1'b0;
            err_len      <= 1'b0;
            err_addr     <= 1'b0;
        end else begin
            state        <= state_next;
            commit_pulse <= 1'b0;

            if (state == IDLE && ss_fall)
                cnt <= '0;
            if ((state == HEADER || state == WDATA || state == RDATA) && sclk_rise) begin
                sr  <= {sr[28:0], mosi_s[1]};
                cnt <= cnt + 6'd1;
            end

            if (state == HEADER && state_next == RDATA) begin
                tx <= rd_val;
                if (hdr_addr != 7'd0 && !is_mapped(hdr_addr))
                    err_addr <= 1'b1;
            end
            // bit 23 is held through the 8th fall; shifting starts at the 9th
            if (state == RDATA && sclk_fall && cnt >= 6'd9)
                tx <= {tx[22:0], 1'b0};

            if (abort || (state == WAIT_SS && sclk_rise))
                err_len <= 1'b1;

            if (frame_end && state == WDATA) begin
                if (fr_addr == 7'd0) begin
                    // clear precedes commit, so clear+commit publishes zeros
                    if (ctrl[1]) shadow <= '0;
                    if (ctrl[0]) begin
                        coef_out     <= ctrl[1] ? '0 : shadow;
                        commit_pulse <= 1'b1;
                    end
                    if (ctrl[2]) begin
                        err_len  <= 1'b0;
                        err_addr <= 1'b0;
                    end
                end else if (is_mapped(fr_addr)) begin
                    shadow[wr_base +: COEF_W] <= wdata;
                end else begin
                    err_addr <= 1'b1;
                end
            end
        end
    end

    assign miso_oe = (state == RDATA);
    assign miso    = (state == RDATA) & tx[23];

endmodule

// File: tb/tb_spi_coeff_bank.sv
// Randomised bench for spi_coeff_bank against a frame-level behavioural model:
// the model applies each whole frame's effect (shadow/active arrays, sticky
// flags) once ss_n is back high, and a compare process checks the idle outputs
// against it every clock between frames.
module tb_spi_coeff_bank;
    localparam int NUM_CH = 4;
    localparam int TAPS   = 8;
    localparam int COEF_W = 5;
    localparam int NE     = NUM_CH * TAPS;
    localparam int BW     = NE * COEF_W;
    localparam int HALF   = 6;   // clk cycles per sclk half period

    logic clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, mosi = 1'b0, ss_n = 1'b1;
    logic miso, miso_oe, commit_pulse, err_len, err_addr;
    logic [BW-1:0] coef_out;

    spi_coeff_bank #(.NUM_CH(NUM_CH), .TAPS(TAPS), .COEF_W(COEF_W)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .mosi(mosi), .ss_n(ss_n),
        .miso(miso), .miso_oe(miso_oe), .coef_out(coef_out),
        .commit_pulse(commit_pulse), .err_len(err_len), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    logic [COEF_W-1:0] m_sh [NE];
    logic [COEF_W-1:0] m_act [NE];
    logic m_el, m_ea;
    bit   chk = 1'b0;
    int   pulses = 0;
    logic [23:0] last_rx;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] exp_coef();
        logic [BW-1:0] v;
        v = '0;
        for (int k = 0; k < NE; k++) v[k*COEF_W +: COEF_W] = m_act[k];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NE; k++) begin
            m_sh[k]  = '0;
            m_act[k] = '0;
        end
        m_el = 1'b0;
        m_ea = 1'b0;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (chk) begin
            check("coef_out", coef_out, exp_coef());
            check("flags", {err_len, err_addr}, {m_el, m_ea});
            check("idle_pins", {miso_oe, miso, commit_pulse}, 3'b000);
        end
        if (commit_pulse) pulses++;
    end

    // Drive one frame of nbits (bits beyond 32 are random). rst_at >= 0 pulls
    // reset right after that rise and returns without finishing the frame.
    task automatic frame(input int nbits, input logic [31:0] word, input bit is_rd,
                         input int rst_at, output logic [23:0] rx, output int oe_bad);
        logic [39:0] bits;
        bit exp_oe;
        bits   = {word, 8'($urandom)};
        rx     = '0;
        oe_bad = 0;
        ss_n   = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < nbits; i++) begin
            mosi = bits[39-i];
            wait_clk(HALF);
            exp_oe = is_rd && i >= 8 && i < 32;
            if (miso_oe !== exp_oe) oe_bad++;
            if (i >= 8 && i < 32) rx[31-i] = miso;
            sclk = 1'b1;
            if (rst_at == i) begin
                wait_clk(2);
                rst_n = 1'b0;
                #1;
                check("rst_coef", coef_out, '0);
                check("rst_pins", {miso, miso_oe, err_len, err_addr, commit_pulse}, 5'b0);
                sclk = 1'b0;
                return;
            end
            wait_clk(HALF);
            sclk = 1'b0;
        end
        wait_clk(HALF);
        ss_n = 1'b1;
        wait_clk(8);
    endtask

    task automatic do_frame(input int nbits, input bit rw, input logic [6:0] addr, input logic [23:0] data);
        logic [23:0] exp_rd, rx;
        int oe_bad, exp_p;
        bit mapped;
        mapped = addr != 0 && int'(addr) <= NE;
        exp_rd = '0;
        if (addr == 0) exp_rd[1:0] = {m_el, m_ea};
        else if (mapped) exp_rd[COEF_W-1:0] = m_sh[int'(addr)-1];
        chk = 1'b0;
        pulses = 0;
        exp_p = 0;
        frame(nbits, {rw, addr, data}, !rw, -1, rx, oe_bad);
        last_rx = rx;
        if (!rw && nbits >= 8 && addr != 0 && !mapped) m_ea = 1'b1;
        if (rw && nbits >= 32) begin
            if (addr == 0) begin
                if (data[1]) for (int k = 0; k < NE; k++) m_sh[k] = '0;
                if (data[0]) begin
                    for (int k = 0; k < NE; k++) m_act[k] = m_sh[k];
                    exp_p = 1;
                end
                if (data[2]) begin m_el = 1'b0; m_ea = 1'b0; end
            end else if (mapped) m_sh[int'(addr)-1] = data[COEF_W-1:0];
            else m_ea = 1'b1;
        end
        if (nbits != 32) m_el = 1'b1;
        check("commit_pulses", 32'(pulses), 32'(exp_p));
        check("miso_oe_window", 32'(oe_bad), 32'd0);
        if (!rw && nbits >= 32) check("read_data", rx, exp_rd);
        chk = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] rx;
        int oe_bad, r, nb;
        logic [6:0]  a;
        logic [23:0] d;
        bit rw;
        model_reset();

        // reset with ss_n already low: no frame may start until ss_n goes high
        ss_n = 1'b0;
        wait_clk(5);
        check("reset_coef", coef_out, '0);
        check("reset_pins", {miso, miso_oe, commit_pulse, err_len, err_addr}, 5'b0);
        rst_n = 1'b1;
        wait_clk(10);
        for (int i = 0; i < 4; i++) begin
            mosi = 1'($urandom);
            sclk = 1'b1; wait_clk(HALF);
            sclk = 1'b0; wait_clk(HALF);
        end
        ss_n = 1'b1;
        wait_clk(10);
        chk = 1'b1;
        check("lit_no_frame_err", err_len, 1'b0);

        // directed walk through the main scenarios
        do_frame(32, 1'b1, 7'h05, 24'h00001F);
        check("lit_no_commit_yet", coef_out, '0);
        do_frame(32, 1'b1, 7'h00, 24'h000001);
        check("lit_committed", coef_out, BW'(32'h01F00000));
        do_frame(32, 1'b0, 7'h05, 24'h0);
        check("lit_readback", last_rx, 24'h00001F);
        do_frame(20, 1'b1, 7'h02, 24'h000015);
        check("lit_abort_err_len", err_len, 1'b1);
        do_frame(32, 1'b0, 7'h02, 24'h0);
        check("lit_abort_no_write", last_rx, 24'h0);
        do_frame(32, 1'b0, 7'h00, 24'h0);
        check("lit_status_read", last_rx, 24'h000002);
        do_frame(32, 1'b1, 7'h00, 24'h000004);
        check("lit_err_cleared", {err_len, err_addr}, 2'b00);
        do_frame(32, 1'b1, 7'h7F, 24'h00000A);
        check("lit_err_addr", err_addr, 1'b1);
        do_frame(33, 1'b1, 7'h03, 24'h00000A);
        check("lit_long_err_len", err_len, 1'b1);
        do_frame(32, 1'b0, 7'h03, 24'h0);
        check("lit_long_wrote", last_rx, 24'h00000A);
        do_frame(32, 1'b1, 7'h21, 24'h000007);
        do_frame(32, 1'b0, 7'h20, 24'h0);
        check("lit_last_entry_empty", last_rx, 24'h0);
        do_frame(32, 1'b1, 7'h00, 24'h000003);
        check("lit_clear_commit", coef_out, '0);

        // randomised frames
        for (int n = 0; n < 45; n++) begin
            rw = 1'($urandom);
            r  = $urandom_range(0, 9);
            if (r < 6)      a = 7'($urandom_range(1, NE));
            else if (r < 8) a = 7'h00;
            else            a = 7'($urandom_range(NE + 1, 127));
            d = 24'($urandom);
            if (a == 0) d = {21'b0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, 1'($urandom)};
            r = $urandom_range(0, 19);
            if (r < 17)      nb = 32;
            else if (r < 19) nb = $urandom_range(1, 31);
            else             nb = $urandom_range(33, 34);
            do_frame(nb, rw, a, d);
        end

        // reset in the middle of a read with a committed bank and flags set
        do_frame(32, 1'b1, 7'h09, 24'h000013);
        do_frame(32, 1'b1, 7'h00, 24'h000001);
        do_frame(32, 1'b1, 7'h50, 24'h0);
        do_frame(5, 1'b1, 7'h01, 24'h0);
        check("lit_pre_reset", {err_len, err_addr}, 2'b11);
        chk = 1'b0;
        frame(32, {1'b0, 7'h09, 24'h0}, 1'b1, 15, rx, oe_bad);
        model_reset();
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(4);
        chk = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sclk = 1'b1; wait_clk(HALF);
            sclk = 1'b0; wait_clk(HALF);
        end
        ss_n = 1'b1;
        wait_clk(10);
        do_frame(32, 1'b0, 7'h09, 24'h0);
        check("lit_shadow_reset", last_rx, 24'h0);

        chk = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
